dsp_mac_rr_scheduler: RTL and testbench

//  Shares one signed multiply-add datapath (P = A + A*B, or P = A - A*B when sub=1) among NUM_REQ requesters.

---
 rtl/dsp_mac_pkg.sv | 49 ++++
 rtl/dsp_mac_rr_scheduler_if.sv | 24 ++
 rtl/dsp_rsp_fifo.sv | 70 +++++++
 rtl/dsp_mac_rr_scheduler.sv | 108 ++++++++++
 tb/tb_dsp_mac_rr_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared types, default widths and the multiply-add evaluation used by the
// shared DSP MAC scheduler.
package dsp_mac_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int A_WIDTH        = 20;
    localparam int B_WIDTH        = 18;
    localparam int P_WIDTH        = A_WIDTH + B_WIDTH;
    localparam int ID_WIDTH       = $clog2(DEF_NUM_REQ);

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } mac_op_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [A_WIDTH-1:0]  a;
        logic [B_WIDTH-1:0]  b;
        mac_op_t             op;
    } mac_req_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [P_WIDTH-1:0]  p;
    } mac_rsp_t;

    // P = A +/- A*B; operands are sign-extended to the result width first, so
    // the modular product equals the truncated full-precision result.
    function automatic logic [P_WIDTH-1:0] mac_eval(
        input logic [A_WIDTH-1:0] a,
        input logic [B_WIDTH-1:0] b,
        input mac_op_t            op
    );
        logic signed [P_WIDTH-1:0] a_ext;
        logic signed [P_WIDTH-1:0] b_ext;
        logic signed [P_WIDTH-1:0] prod;
        a_ext = P_WIDTH'($signed(a));
        b_ext = P_WIDTH'($signed(b));
        prod  = a_ext * b_ext;
        case (op)
            OP_ADD:  return a_ext + prod;
            OP_SUB:  return a_ext - prod;
            default: return a_ext + prod;
        endcase
    endfunction

endpackage

// File: rtl/dsp_mac_rr_scheduler_if.sv
// Request/response bundle between DSP requesters and the shared MAC scheduler.
interface dsp_mac_rr_scheduler_if #(
    parameter int NUM_REQ = dsp_mac_pkg::DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]                      req_valid;
    logic [NUM_REQ-1:0]                      req_ready;
    logic [NUM_REQ*dsp_mac_pkg::A_WIDTH-1:0] req_a;
    logic [NUM_REQ*dsp_mac_pkg::B_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]                      req_sub;
    logic                                    rsp_valid;
    logic                                    rsp_ready;
    logic [dsp_mac_pkg::ID_WIDTH-1:0]        rsp_id;
    logic [dsp_mac_pkg::P_WIDTH-1:0]         rsp_p;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/dsp_rsp_fifo.sv
// Response FIFO holding completed MAC results in issue order; head is shown
// directly from storage, so a pushed entry becomes visible one cycle later.
module dsp_rsp_fifo
    import dsp_mac_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  mac_rsp_t push_data,
    input  logic     pop,
    output logic     empty,
    output mac_rsp_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    mac_rsp_t          mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_s;
    logic              do_push_s;
    logic              do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full_s | do_pop_s);
    assign head      = mem_r[rd_ptr_r];

    // Entry storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dsp_mac_rr_scheduler.sv
// Round-robin scheduler sharing one signed multiply-add datapath among
// NUM_REQ requesters, with credit flow control and in-order tagged responses.
module dsp_mac_rr_scheduler
    import dsp_mac_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic                    clk,
    input logic                    reset,
    dsp_mac_rr_scheduler_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_WIDTH-1:0] rr_ptr_r;
    logic [CNT_W-1:0]    credit_r;
    logic                s1_valid_r;
    mac_req_t            s1_req_r;

    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_WIDTH-1:0] grant_id_s;
    logic                grant_any_s;
    logic                hit_s;
    int                  idx_s;
    logic                credit_ok_s;
    logic                accept_s;
    logic                pop_s;
    logic                fifo_empty_s;
    mac_req_t            sel_req_s;
    mac_rsp_t            push_rsp_s;
    mac_rsp_t            head_s;

    // Round-robin search starting at rr_ptr_r, wrapping modulo NUM_REQ
    always_comb begin
        grant_s     = '0;
        grant_id_s  = '0;
        grant_any_s = 1'b0;
        hit_s       = 1'b0;
        idx_s       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s          = int'(rr_ptr_r) + k;
            idx_s          = (idx_s >= NUM_REQ) ? idx_s - NUM_REQ : idx_s;
            hit_s          = ~grant_any_s & bus.req_valid[idx_s];
            grant_s[idx_s] = hit_s;
            grant_id_s     = hit_s ? ID_WIDTH'(idx_s) : grant_id_s;
            grant_any_s    = grant_any_s | hit_s;
        end
    end

    // A pop in the same cycle does not free a credit until the next cycle
    assign credit_ok_s   = (credit_r < CNT_W'(FIFO_DEPTH));
    assign bus.req_ready = (reset || !credit_ok_s) ? '0 : grant_s;
    assign accept_s      = |(bus.req_valid & bus.req_ready);

    // Operand select for the granted requester
    always_comb begin
        sel_req_s    = '0;
        sel_req_s.id = grant_id_s;
        sel_req_s.a  = bus.req_a[int'(grant_id_s)*A_WIDTH +: A_WIDTH];
        sel_req_s.b  = bus.req_b[int'(grant_id_s)*B_WIDTH +: B_WIDTH];
        sel_req_s.op = bus.req_sub[grant_id_s] ? OP_SUB : OP_ADD;
    end

    // Arbiter pointer, credit counter and stage-1 operand register
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r   <= '0;
            credit_r   <= '0;
            s1_valid_r <= 1'b0;
            s1_req_r   <= '0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_req_r <= sel_req_s;
                rr_ptr_r <= (grant_id_s == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                    : grant_id_s + ID_WIDTH'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   credit_r <= credit_r + CNT_W'(1);
                2'b01:   credit_r <= credit_r - CNT_W'(1);
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Stage 2: the multiply-add result is captured directly by the FIFO
    assign push_rsp_s.id = s1_req_r.id;
    assign push_rsp_s.p  = mac_eval(s1_req_r.a, s1_req_r.b, s1_req_r.op);

    dsp_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s1_valid_r),
        .push_data (push_rsp_s),
        .pop       (pop_s),
        .empty     (fifo_empty_s),
        .head      (head_s)
    );

    assign bus.rsp_valid = ~fifo_empty_s & ~reset;
    assign bus.rsp_id    = reset ? '0 : head_s.id;
    assign bus.rsp_p     = reset ? '0 : head_s.p;
    assign pop_s         = bus.rsp_valid & bus.rsp_ready;

endmodule

// File: tb/tb_dsp_mac_rr_scheduler.sv
// Self-checking bench for dsp_mac_rr_scheduler: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_dsp_mac_rr_scheduler;
    import dsp_mac_pkg::*;

    localparam int NR = 4;
    localparam int FD = 4;
    localparam int AW = A_WIDTH;
    localparam int BW = B_WIDTH;
    localparam int PW = P_WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dsp_mac_rr_scheduler_if #(.NUM_REQ(NR)) bus ();

    dsp_mac_rr_scheduler #(
        .NUM_REQ    (NR),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, act, act, exp, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [PW-1:0] ref_p(input int a, input int b, input bit sub);
        longint     prod;
        longint     res;
        logic [63:0] r;
        prod = longint'(a) * longint'(b);
        res  = sub ? (longint'(a) - prod) : (longint'(a) + prod);
        r    = res;
        return r[PW-1:0];
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) begin
            if (v[i] && r < 0) r = i;
        end
        return r;
    endfunction

    // Reference model: accepted operations in accept order, each visible as a
    // response two cycles after its accept; outstanding count = queue size.
    typedef struct {
        int id;
        int a;
        int b;
        bit sub;
        int cyc;
    } op_t;

    op_t            q[$];
    int             rr       = 0;
    int             cyc      = 0;
    int             acc_cnt  = 0;
    logic [NR-1:0]  seen_acc = '0;

    always @(negedge clk) begin : monitor
        logic [NR-1:0] exp_ready;
        int            g;
        int            i;
        bit            exp_rv;
        op_t           op;
        exp_ready = '0;
        g         = -1;
        if (reset) begin
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_rsp_id",    bus.rsp_id,    0);
            check("rst_rsp_p",     bus.rsp_p,     0);
            q.delete();
            rr = 0;
        end else begin
            if (q.size() < FD) begin
                for (int k = 0; k < NR; k++) begin
                    i = (rr + k) % NR;
                    if (g < 0 && bus.req_valid[i]) g = i;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", bus.req_ready, exp_ready);
            exp_rv = (q.size() > 0) && (cyc >= q[0].cyc + 2);
            check("rsp_valid", bus.rsp_valid, exp_rv);
            if (exp_rv) begin
                check("rsp_id", bus.rsp_id, q[0].id);
                check("rsp_p",  bus.rsp_p,  ref_p(q[0].a, q[0].b, q[0].sub));
                if (bus.rsp_ready) void'(q.pop_front());
            end
            if (g >= 0) begin
                op.id  = g;
                op.a   = int'($signed(bus.req_a[g*AW +: AW]));
                op.b   = int'($signed(bus.req_b[g*BW +: BW]));
                op.sub = bus.req_sub[g];
                op.cyc = cyc;
                q.push_back(op);
                rr = (g + 1) % NR;
                acc_cnt++;
            end
        end
        seen_acc = bus.req_ready & bus.req_valid;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*AW +: AW] = AW'($urandom());
            bus.req_b[i*BW +: BW] = BW'($urandom());
            bus.req_sub[i]        = 1'($urandom_range(0, 1));
        end
    endtask

    // Single isolated request: checks grant, 2-cycle latency, id and result
    task automatic issue_one(input int id, input int a, input int b, input bit sub,
                             input logic [PW-1:0] exp_p, input string tag);
        bit hit;
        int lat;
        bus.req_valid          = '0;
        bus.req_valid[id]      = 1'b1;
        bus.req_a[id*AW +: AW] = AW'(a);
        bus.req_b[id*BW +: BW] = BW'(b);
        bus.req_sub[id]        = sub;
        bus.rsp_ready          = 1'b1;
        hit = 1'b0;
        for (int w = 0; w < 20 && !hit; w++) begin
            @(negedge clk);
            hit = bus.req_ready[id];
        end
        check({tag, "_grant"}, hit, 1);
        tick();
        bus.req_valid = '0;
        hit = 1'b0;
        lat = 0;
        while (!hit && lat < 20) begin
            @(negedge clk);
            lat++;
            hit = bus.rsp_valid;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_id"}, bus.rsp_id, id);
        check({tag, "_p"}, bus.rsp_p, exp_p);
        tick();
    endtask

    initial begin : stim
        logic [NR-1:0] vld;
        int            n;
        int            got;
        int            ids[4];
        int            target;
        bit            resumed;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b1;
        reset         = 1'b1;

        // 1: reset with every requester valid
        rand_data();
        bus.req_valid = '1;
        repeat (2) begin
            @(negedge clk);
            check("t1_req_ready", bus.req_ready, 0);
            check("t1_rsp_valid", bus.rsp_valid, 0);
        end
        tick();
        reset         = 1'b0;
        bus.req_valid = '0;
        tick();

        // 2: basic add and subtract on requester 0
        issue_one(0, 5, 2, 1'b0, 38'd15, "t2_add");
        issue_one(0, 5, 2, 1'b1, -38'sd5, "t2_sub");

        // 3: all requesters valid continuously from reset
        do_reset();
        rand_data();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t3_rr_order", oh2idx(bus.req_ready), i % NR);
        end
        tick();
        bus.req_valid = '0;
        repeat (6) tick();

        // 4: consumer stalled, credits exhaust at FIFO_DEPTH
        do_reset();
        rand_data();
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (|bus.req_ready) n++;
        end
        check("t4_accepts", n, 4);
        check("t4_blocked", bus.req_ready, 0);
        tick();
        bus.rsp_ready = 1'b1;
        got     = 0;
        resumed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid && got < 4) begin
                ids[got] = int'(bus.rsp_id);
                got++;
            end
            if (|bus.req_ready) resumed = 1'b1;
        end
        check("t4_rsp_count", got, 4);
        for (int i = 0; i < 4; i++) check("t4_rsp_order", ids[i], i);
        check("t4_resumed", resumed, 1);
        tick();
        bus.req_valid = '0;
        repeat (8) tick();

        // 5: operand extremes on requester 3
        issue_one(3, -524288, -131072, 1'b0, 38'sd68718952448, "t5_add");
        issue_one(3, -524288, -131072, 1'b1, -38'sd68720001024, "t5_sub");

        // 6: reset while results are in flight and buffered
        do_reset();
        rand_data();
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clk);
            if (|bus.req_ready) n++;
        end
        check("t6_accepts", n, 3);
        tick();
        reset         = 1'b1;
        bus.req_valid = '0;
        tick();
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) n++;
        end
        check("t6_stale_rsp", n, 0);
        tick();
        bus.req_valid = '1;
        @(negedge clk);
        check("t6_rr_restart", oh2idx(bus.req_ready), 0);
        tick();
        bus.req_valid = '0;
        repeat (6) tick();

        // Random traffic: 1000 accepted requests with a random consumer
        vld    = '0;
        target = acc_cnt + 1000;
        for (int guard = 0; guard < 20000 && acc_cnt < target; guard++) begin
            for (int i = 0; i < NR; i++) begin
                if (!vld[i] || seen_acc[i]) begin
                    vld[i] = ($urandom_range(0, 2) != 0);
                    case ($urandom_range(0, 7))
                        0: begin
                            bus.req_a[i*AW +: AW] = {1'b1, {(AW-1){1'b0}}};
                            bus.req_b[i*BW +: BW] = {1'b1, {(BW-1){1'b0}}};
                        end
                        1: begin
                            bus.req_a[i*AW +: AW] = {1'b0, {(AW-1){1'b1}}};
                            bus.req_b[i*BW +: BW] = {1'b1, {(BW-1){1'b0}}};
                        end
                        default: begin
                            bus.req_a[i*AW +: AW] = AW'($urandom());
                            bus.req_b[i*BW +: BW] = BW'($urandom());
                        end
                    endcase
                    bus.req_sub[i] = 1'($urandom_range(0, 1));
                end
            end
            bus.req_valid = vld;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        check("rand_completed", (acc_cnt >= target), 1);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("rand_drained", bus.rsp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
